// File: rtl/store_rmw_if.sv
// rtl/store_rmw_if.sv - store request and data-memory port bundle for store_rmw_unit
interface store_rmw_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              done;
  logic              err;

  // Environment side: issues store requests and models the data memory.
  modport master (
    output req_valid, req_addr, req_data, req_size, mem_rdata,
    input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, mem_be, done, err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_rdata,
    output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, mem_be, done, err
  );
endinterface

// File: rtl/store_rmw_unit.sv
// rtl/store_rmw_unit.sv - byte/halfword/word store unit with read-modify-write for sub-word lanes
module store_rmw_unit #(
  parameter int ADDR_W = 8
) (
  input logic        clk,
  input logic        rst,
  store_rmw_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_ERR
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state;
  logic        half_q;
  logic [1:0]  off_q;
  logic [15:0] data_q;
  logic        illegal;

  // Big-endian lanes: offset 0 is bit 3 of the mask (bits 31:24).
  function automatic logic [3:0] lane_mask(input logic half, input logic [1:0] off);
    if (half)
      return off[1] ? 4'b0011 : 4'b1100;
    return 4'b1000 >> off;
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [15:0] d,
                                             input logic        half,
                                             input logic [1:0]  off);
    logic [3:0]  m;
    logic [31:0] ins;
    logic [31:0] m32;
    m   = lane_mask(half, off);
    ins = half ? {d, d} : {4{d[7:0]}};
    m32 = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old_word & ~m32) | (ins & m32);
  endfunction

  always_comb begin
    illegal = 1'b0;
    case (bus.req_size)
      SZ_HALF: illegal = bus.req_addr[0];
      SZ_WORD: illegal = |bus.req_addr[1:0];
      SZ_BYTE: illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.req_ready <= 1'b1;
      bus.mem_rd_en <= 1'b0;
      bus.mem_wr_en <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      half_q        <= 1'b0;
      off_q         <= '0;
      data_q        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            if (illegal) begin
              bus.err <= 1'b1;
              state   <= S_ERR;
            end else if (bus.req_size == SZ_WORD) begin
              bus.mem_addr  <= bus.req_addr[ADDR_W+1:2];
              bus.mem_wr_en <= 1'b1;
              bus.mem_wdata <= bus.req_data;
              bus.mem_be    <= 4'b1111;
              bus.done      <= 1'b1;
              state         <= S_WRITE;
            end else begin
              bus.mem_addr  <= bus.req_addr[ADDR_W+1:2];
              bus.mem_rd_en <= 1'b1;
              half_q        <= (bus.req_size == SZ_HALF);
              off_q         <= bus.req_addr[1:0];
              data_q        <= bus.req_data[15:0];
              state         <= S_READ;
            end
          end
        end

        S_READ: begin
          bus.mem_rd_en <= 1'b0;
          state         <= S_WAIT;
        end

        // Read data from the synchronous memory is valid in this cycle.
        S_WAIT: begin
          bus.mem_wdata <= merge_word(bus.mem_rdata, data_q, half_q, off_q);
          bus.mem_be    <= lane_mask(half_q, off_q);
          bus.mem_wr_en <= 1'b1;
          bus.done      <= 1'b1;
          state         <= S_WRITE;
        end

        S_WRITE: begin
          bus.mem_wr_en <= 1'b0;
          bus.done      <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= S_IDLE;
        end

        S_ERR: begin
          bus.err       <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= S_IDLE;
        end

        default: begin
          bus.mem_rd_en <= 1'b0;
          bus.mem_wr_en <= 1'b0;
          bus.done      <= 1'b0;
          bus.err       <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// tb/tb_store_rmw_unit.sv - randomized self-checking bench for store_rmw_unit
`timescale 1ns/1ps
module tb_store_rmw_unit;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_rmw_if #(.ADDR_W(ADDR_W)) bus();

  store_rmw_unit #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        pl_en   = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] last_w;
  logic [3:0]  last_be;

  // Synchronous data memory; read data is garbage except the cycle after a read strobe.
  always @(posedge clk) begin
    if (pl_en)
      mem[pl_addr] <= pl_data;
    else if (bus.mem_wr_en)
      mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd_en)
      bus.mem_rdata <= mem[bus.mem_addr];
    else
      bus.mem_rdata <= $urandom;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pl_en   = 1'b1;
    pl_addr = idx;
    pl_data = val;
    ref_mem[idx] = val;
    step();
    pl_en = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    logic [7:0]  b [4];
    logic [31:0] exp_w;
    logic [3:0]  exp_be;
    logic        legal;
    logic [7:0]  widx;
    logic        overlap;
    logic        addr_bad;
    int k, wait_n;
    int rd_n, rd_c, wr_n, wr_c, dn_n, dn_c, er_n, er_c, rdy_c;
    int exp_rd_n, exp_rd_c, exp_wr_n, exp_wr_c, exp_er_n, exp_er_c, exp_rdy_c;

    k     = int'(a[1:0]);
    widx  = a[9:2];
    legal = !((sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00));
    for (int i = 0; i < 4; i++) b[i] = ref_mem[widx][31-8*i -: 8];
    exp_be = 4'b0000;
    if (legal) begin
      if (sz == 2'b00) begin
        b[k] = d[7:0];
        exp_be[3-k] = 1'b1;
      end else if (sz == 2'b01) begin
        b[k]   = d[15:8];
        b[k+1] = d[7:0];
        exp_be[3-k] = 1'b1;
        exp_be[2-k] = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) b[i] = d[31-8*i -: 8];
        exp_be = 4'b1111;
      end
    end
    exp_w     = {b[0], b[1], b[2], b[3]};
    exp_rd_n  = (legal && sz != 2'b10) ? 1 : 0;
    exp_rd_c  = exp_rd_n;
    exp_wr_n  = legal ? 1 : 0;
    exp_wr_c  = !legal ? 0 : (sz == 2'b10) ? 1 : 3;
    exp_er_n  = legal ? 0 : 1;
    exp_er_c  = exp_er_n;
    exp_rdy_c = legal ? exp_wr_c + 1 : 2;

    wait_n = 0;
    while (!bus.req_ready && wait_n < 8) begin
      step();
      wait_n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_timeout a=%h actual=%b expected=1", a, bus.req_ready);
    end

    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = sz;
    step();
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_data  = $urandom;
    bus.req_size  = 2'($urandom);

    rd_n = 0; rd_c = 0; wr_n = 0; wr_c = 0; dn_n = 0; dn_c = 0; er_n = 0; er_c = 0; rdy_c = 0;
    overlap = 1'b0; addr_bad = 1'b0; last_w = 'x; last_be = 'x;
    for (int c = 1; c <= 6; c++) begin
      if (bus.mem_rd_en) begin rd_n++; rd_c = c; end
      if (bus.mem_wr_en) begin wr_n++; wr_c = c; last_w = bus.mem_wdata; last_be = bus.mem_be; end
      if (bus.done) begin dn_n++; dn_c = c; end
      if (bus.err) begin er_n++; er_c = c; end
      if (bus.mem_rd_en && bus.mem_wr_en) overlap = 1'b1;
      if (legal && c <= exp_wr_c && bus.mem_addr !== widx) addr_bad = 1'b1;
      if (bus.req_ready && rdy_c == 0) rdy_c = c;
      if (c < 6) step();
    end

    checks++;
    if (overlap !== 1'b0) begin
      failures++;
      $display("FAIL strobe_overlap a=%h actual=%b expected=0", a, overlap);
    end
    checks++;
    if (addr_bad !== 1'b0) begin
      failures++;
      $display("FAIL mem_addr_hold a=%h actual_bad=%b expected word=%h", a, addr_bad, widx);
    end
    checks++;
    if ({rd_n, rd_c} !== {exp_rd_n, exp_rd_c}) begin
      failures++;
      $display("FAIL rd_strobe a=%h sz=%b actual n=%0d cyc=%0d expected n=%0d cyc=%0d", a, sz, rd_n, rd_c, exp_rd_n, exp_rd_c);
    end
    checks++;
    if ({wr_n, wr_c} !== {exp_wr_n, exp_wr_c}) begin
      failures++;
      $display("FAIL wr_strobe a=%h sz=%b actual n=%0d cyc=%0d expected n=%0d cyc=%0d", a, sz, wr_n, wr_c, exp_wr_n, exp_wr_c);
    end
    checks++;
    if ({dn_n, dn_c} !== {exp_wr_n, exp_wr_c}) begin
      failures++;
      $display("FAIL done_pulse a=%h actual n=%0d cyc=%0d expected n=%0d cyc=%0d", a, dn_n, dn_c, exp_wr_n, exp_wr_c);
    end
    checks++;
    if ({er_n, er_c} !== {exp_er_n, exp_er_c}) begin
      failures++;
      $display("FAIL err_pulse a=%h sz=%b actual n=%0d cyc=%0d expected n=%0d cyc=%0d", a, sz, er_n, er_c, exp_er_n, exp_er_c);
    end
    checks++;
    if (rdy_c !== exp_rdy_c) begin
      failures++;
      $display("FAIL ready_return a=%h actual cyc=%0d expected cyc=%0d", a, rdy_c, exp_rdy_c);
    end
    if (legal) begin
      checks++;
      if (last_w !== exp_w) begin
        failures++;
        $display("FAIL wdata a=%h sz=%b actual=%h expected=%h", a, sz, last_w, exp_w);
      end
      checks++;
      if (last_be !== exp_be) begin
        failures++;
        $display("FAIL be a=%h sz=%b actual=%b expected=%b", a, sz, last_be, exp_be);
      end
      ref_mem[widx] = exp_w;
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_size  = '0;
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready actual=%b expected=1", bus.req_ready);
    end
    checks++;
    if ({bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes actual=%b expected=0000", {bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.err});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== '0) begin
      failures++;
      $display("FAIL reset_regs actual addr=%h wdata=%h be=%b expected 0", bus.mem_addr, bus.mem_wdata, bus.mem_be);
    end
    rst = 1'b0;
    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
  endtask

  task automatic test_directed();
    do_store(32'h10, 32'hDEADBEEF, 2'b10);
    checks++;
    if ({last_w, last_be} !== {32'hDEADBEEF, 4'b1111}) begin
      failures++;
      $display("FAIL sw_const actual=%h/%b expected=deadbeef/1111", last_w, last_be);
    end
    preload(8'd4, 32'h11223344);
    do_store(32'h11, 32'h123456AB, 2'b00);
    checks++;
    if ({last_w, last_be} !== {32'h11AB3344, 4'b0100}) begin
      failures++;
      $display("FAIL sb_const actual=%h/%b expected=11ab3344/0100", last_w, last_be);
    end
    preload(8'd8, 32'hAABBCCDD);
    do_store(32'h22, 32'hFFFFCAFE, 2'b01);
    checks++;
    if ({last_w, last_be} !== {32'hAABBCAFE, 4'b0011}) begin
      failures++;
      $display("FAIL sh_lo_const actual=%h/%b expected=aabbcafe/0011", last_w, last_be);
    end
    preload(8'd8, 32'hAABBCCDD);
    do_store(32'h20, 32'hFFFFCAFE, 2'b01);
    checks++;
    if ({last_w, last_be} !== {32'hCAFECCDD, 4'b1100}) begin
      failures++;
      $display("FAIL sh_hi_const actual=%h/%b expected=cafeccdd/1100", last_w, last_be);
    end
  endtask

  task automatic test_illegal();
    do_store(32'h13, 32'h0000BEEF, 2'b01);
    do_store(32'h12, 32'h01020304, 2'b10);
    do_store(32'h10, 32'h05060708, 2'b11);
  endtask

  task automatic test_reset_mid();
    logic saw_wr;
    preload(8'h30, 32'h55667788);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hC1;
    bus.req_data  = 32'h00000099;
    bus.req_size  = 2'b00;
    step();
    bus.req_valid = 1'b0;
    checks++;
    if (bus.mem_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_read actual=%b expected=1", bus.mem_rd_en);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.err} !== 5'b10000) begin
      failures++;
      $display("FAIL rstmid_outputs actual=%b expected=10000",
               {bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.err});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== '0) begin
      failures++;
      $display("FAIL rstmid_regs actual addr=%h wdata=%h be=%b expected 0", bus.mem_addr, bus.mem_wdata, bus.mem_be);
    end
    rst = 1'b0;
    saw_wr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.mem_wr_en) saw_wr = 1'b1;
      step();
    end
    checks++;
    if ({saw_wr, mem[8'h30]} !== {1'b0, 32'h55667788}) begin
      failures++;
      $display("FAIL rstmid_no_write actual wr=%b word=%h expected wr=0 word=55667788", saw_wr, mem[8'h30]);
    end
    do_store(32'hC1, 32'h00000099, 2'b00);
    checks++;
    if (last_w !== 32'h55997788) begin
      failures++;
      $display("FAIL rstmid_next actual=%h expected=55997788", last_w);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1, d2;
    int wait_n;
    d1 = $urandom;
    d2 = $urandom;
    wait_n = 0;
    while (!bus.req_ready && wait_n < 8) begin
      step();
      wait_n++;
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_data  = d1;
    bus.req_size  = 2'b10;
    step();
    checks++;
    if ({bus.req_ready, bus.mem_wr_en, bus.mem_wdata} !== {1'b0, 1'b1, d1}) begin
      failures++;
      $display("FAIL b2b_t1 actual rdy=%b wr=%b wdata=%h expected rdy=0 wr=1 wdata=%h",
               bus.req_ready, bus.mem_wr_en, bus.mem_wdata, d1);
    end
    bus.req_addr = 32'h44;
    bus.req_data = d2;
    step();
    checks++;
    if ({bus.req_ready, bus.mem_wr_en} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_t2 actual rdy=%b wr=%b expected rdy=1 wr=0", bus.req_ready, bus.mem_wr_en);
    end
    step();
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.mem_wr_en, bus.done, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 8'h11, d2}) begin
      failures++;
      $display("FAIL b2b_t3 actual wr=%b done=%b addr=%h wdata=%h expected wr=1 done=1 addr=11 wdata=%h",
               bus.mem_wr_en, bus.done, bus.mem_addr, bus.mem_wdata, d2);
    end
    step();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_t4 actual rdy=%b expected=1", bus.req_ready);
    end
    ref_mem[8'h10] = d1;
    ref_mem[8'h11] = d2;
  endtask

  task automatic test_random();
    int bad;
    for (int n = 0; n < 150; n++)
      do_store($urandom, $urandom, 2'($urandom_range(0, 3)));
    step();
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL memory_image actual_mismatched_words=%0d expected=0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
